button_pio_debounced: RTL



---
 rtl/button_pio_debounced.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_pio_debounced.sv
// Avalon-MM PIO for WIDTH debounced button/switch pins with sticky edge capture.
// Define BUTTON_PIO_IRQ_EN to implement IRQMASK and a registered level irq.
module button_pio_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 1,
  parameter int RESET_LEVEL     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RAW     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  localparam logic [WIDTH-1:0] RST_VEC = (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_deb_q;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  addr_e            w_addr;
  logic             w_wr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_irqmask;
  logic [31:0]      w_rd_mux;
  logic             w_unused_ok;

  assign w_addr      = addr_e'(address);
  assign w_wr        = chipselect & ~write_n;
  assign w_unused_ok = &{1'b0, writedata};

  // NOTE: sequential state uses <= so every flop samples pre-edge values, like real hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RST_VEC;
      r_sync2 <= RST_VEC;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_deb <= RST_VEC;
        else          r_deb <= r_sync2;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt [WIDTH];

      // A pin must disagree with deb for DEBOUNCE_CYCLES straight samples before deb follows.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_deb <= RST_VEC;
          // NOTE: this counter array is plain flops, not RAM, so it is reset element by element.
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_deb[i] <= r_sync2[i];
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign w_rise = r_deb & ~r_deb_q;
  assign w_fall = ~r_deb & r_deb_q;
  assign w_edge = (EDGE_TYPE == 0) ? w_rise :
                  (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);
  assign w_clr  = (w_wr && w_addr == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_q   <= RST_VEC;
      r_edgecap <= '0;
    end else begin
      r_deb_q   <= r_deb;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

`ifdef BUTTON_PIO_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;
  logic             r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && w_addr == ADDR_IRQMASK) r_irqmask <= writedata[WIDTH-1:0];
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign w_irqmask = r_irqmask;
  assign irq       = r_irq;
`else
  assign w_irqmask = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    // NOTE: default first so every path assigns w_rd_mux and no latch is inferred.
    w_rd_mux = '0;
    case (w_addr)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = r_deb;
      ADDR_RAW:     w_rd_mux[WIDTH-1:0] = r_sync2;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = w_irqmask;
      ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;

endmodule
